// File: rtl/v_regfile_seq.sv
// Vector register file with a built-in element sequencer: streams (vs1[i], vs2[i], v0 mask)
// for one instruction over valid/ready, takes mask-gated writebacks, and zero-sweeps after reset.
module v_regfile_seq #(
  parameter int NREG  = 32,
  parameter int NELEM = 10,
  parameter int ELEN  = 32,
  parameter int RW    = 5,
  parameter int EIW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            start_ready,
  input  logic [RW-1:0]   vs1,
  input  logic [RW-1:0]   vs2,
  input  logic [EIW:0]    vl,
  input  logic            vm,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [EIW-1:0]  rd_idx,
  output logic [ELEN-1:0] vs1_data,
  output logic [ELEN-1:0] vs2_data,
  output logic            rd_mask,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_reg,
  input  logic [EIW-1:0]  wb_idx,
  input  logic [ELEN-1:0] wb_data,
  output logic            busy,
  output logic            done
);

  localparam int RXW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int EXW = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [RW:0]  NREG_W  = (RW+1)'(NREG);
  localparam logic [EIW:0] NELEM_W = (EIW+1)'(NELEM);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [RW-1:0]   vs1_q, vs1_d;
  logic [RW-1:0]   vs2_q, vs2_d;
  logic            vm_q, vm_d;
  logic [EIW:0]    vl_q, vl_d;
  logic [EIW:0]    rd_cnt_q, rd_cnt_d;
  logic [EIW:0]    wb_cnt_q, wb_cnt_d;
  logic            rd_valid_q, rd_valid_d;
  logic [EIW-1:0]  rd_idx_q, rd_idx_d;
  logic [ELEN-1:0] vs1_data_q, vs1_data_d;
  logic [ELEN-1:0] vs2_data_q, vs2_data_d;
  logic            rd_mask_q, rd_mask_d;
  logic            done_q, done_d;

  logic [ELEN-1:0] mem_q [NREG][NELEM];

  logic            clr_we;
  logic [RXW-1:0]  clr_rx;
  logic            wb_we;
  logic            wb_idx_ok;
  logic            wb_reg_ok;
  logic [EXW-1:0]  wb_ix;
  logic [RXW-1:0]  wb_rx;
  logic            v0_bit;

  logic            ld_en;
  logic [RW-1:0]   ld_r1;
  logic [RW-1:0]   ld_r2;
  logic [EIW-1:0]  ld_idx;
  logic            ld_vm;
  logic [EXW-1:0]  ld_ix;
  logic            ld_r1_ok;
  logic            ld_r2_ok;
  logic            byp1;
  logic            byp2;
  logic            byp0;

  logic            rd_hs;
  logic [EIW:0]    rd_cnt_nx;
  logic [EIW:0]    wb_cnt_nx;
  logic [EIW:0]    vl_clamp;

  // Write port: unmasked in IDLE, v0-gated in RUN, ignored during the clear sweep.
  always_comb begin
    clr_we    = (state_q == ST_CLEAR);
    clr_rx    = clr_cnt_q[RXW-1:0];
    wb_idx_ok = ({1'b0, wb_idx} < NELEM_W);
    wb_reg_ok = ({1'b0, wb_reg} < NREG_W);
    wb_ix     = wb_idx_ok ? wb_idx[EXW-1:0] : '0;
    wb_rx     = wb_reg[RXW-1:0];
    v0_bit    = mem_q[RXW'(0)][wb_ix][0];
    wb_we     = 1'b0;
    if (wb_valid && wb_idx_ok && wb_reg_ok) begin
      if (state_q == ST_IDLE) begin
        wb_we = 1'b1;
      end else if (state_q == ST_RUN) begin
        wb_we = vm_q | v0_bit;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    vm_d       = vm_q;
    vl_d       = vl_q;
    rd_cnt_d   = rd_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    ld_en      = 1'b0;
    ld_r1      = vs1_q;
    ld_r2      = vs2_q;
    ld_idx     = rd_idx_q;
    ld_vm      = vm_q;
    rd_hs      = rd_valid_q && rd_ready;
    vl_clamp   = (vl > NELEM_W) ? NELEM_W : vl;
    rd_cnt_nx  = rd_cnt_q + {{EIW{1'b0}}, rd_hs};
    wb_cnt_nx  = wb_cnt_q + {{EIW{1'b0}}, (wb_valid && (wb_cnt_q != '1))};

    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == RW'(NREG - 1)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + RW'(1);
        end
      end
      ST_IDLE: begin
        if (start) begin
          vs1_d    = vs1;
          vs2_d    = vs2;
          vm_d     = vm;
          vl_d     = vl_clamp;
          rd_cnt_d = '0;
          wb_cnt_d = '0;
          if (vl_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_RUN;
            rd_valid_d = 1'b1;
            ld_en      = 1'b1;
            ld_r1      = vs1;
            ld_r2      = vs2;
            ld_idx     = '0;
            ld_vm      = vm;
          end
        end
      end
      ST_RUN: begin
        rd_cnt_d = rd_cnt_nx;
        wb_cnt_d = wb_cnt_nx;
        if (rd_hs) begin
          if (rd_cnt_nx < vl_q) begin
            ld_en  = 1'b1;
            ld_idx = rd_idx_q + EIW'(1);
          end else begin
            rd_valid_d = 1'b0;
          end
        end
        if ((rd_cnt_nx >= vl_q) && (wb_cnt_nx >= vl_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Operand load with same-edge writeback bypass.
  always_comb begin
    ld_ix      = ld_idx[EXW-1:0];
    ld_r1_ok   = ({1'b0, ld_r1} < NREG_W);
    ld_r2_ok   = ({1'b0, ld_r2} < NREG_W);
    byp1       = wb_we && (wb_reg == ld_r1) && (wb_idx == ld_idx);
    byp2       = wb_we && (wb_reg == ld_r2) && (wb_idx == ld_idx);
    byp0       = wb_we && (wb_reg == '0) && (wb_idx == ld_idx);
    rd_idx_d   = rd_idx_q;
    vs1_data_d = vs1_data_q;
    vs2_data_d = vs2_data_q;
    rd_mask_d  = rd_mask_q;
    if (ld_en) begin
      rd_idx_d   = ld_idx;
      vs1_data_d = '0;
      vs2_data_d = '0;
      if (ld_r1_ok) begin
        vs1_data_d = byp1 ? wb_data : mem_q[ld_r1[RXW-1:0]][ld_ix];
      end
      if (ld_r2_ok) begin
        vs2_data_d = byp2 ? wb_data : mem_q[ld_r2[RXW-1:0]][ld_ix];
      end
      rd_mask_d = 1'b1;
      if (!ld_vm) begin
        rd_mask_d = byp0 ? wb_data[0] : mem_q[RXW'(0)][ld_ix][0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vm_q       <= 1'b0;
      vl_q       <= '0;
      rd_cnt_q   <= '0;
      wb_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      vs1_data_q <= '0;
      vs2_data_q <= '0;
      rd_mask_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      vm_q       <= vm_d;
      vl_q       <= vl_d;
      rd_cnt_q   <= rd_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      vs1_data_q <= vs1_data_d;
      vs2_data_q <= vs2_data_d;
      rd_mask_q  <= rd_mask_d;
      done_q     <= done_d;
    end
  end

  // Array storage has no reset; the CLEAR sweep zeroes it one register per cycle.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      for (int e = 0; e < NELEM; e++) begin
        mem_q[clr_rx][EXW'(e)] <= '0;
      end
    end else if (wb_we) begin
      mem_q[wb_rx][wb_ix] <= wb_data;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign rd_valid    = rd_valid_q;
  assign rd_idx      = rd_idx_q;
  assign vs1_data    = vs1_data_q;
  assign vs2_data    = vs2_data_q;
  assign rd_mask     = rd_mask_q;

endmodule

// File: tb/tb_v_regfile_seq.sv
// Randomized bench for v_regfile_seq: a cycle-level behavioural model of the register file and
// instruction bookkeeping predicts every output each cycle.
module tb_v_regfile_seq;

  localparam int NREG  = 32;
  localparam int NELEM = 10;
  localparam int ELEN  = 32;
  localparam int RW    = 5;
  localparam int EIW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            start_ready;
  logic [RW-1:0]   vs1;
  logic [RW-1:0]   vs2;
  logic [EIW:0]    vl;
  logic            vm;
  logic            rd_valid;
  logic            rd_ready;
  logic [EIW-1:0]  rd_idx;
  logic [ELEN-1:0] vs1_data;
  logic [ELEN-1:0] vs2_data;
  logic            rd_mask;
  logic            wb_valid;
  logic [RW-1:0]   wb_reg;
  logic [EIW-1:0]  wb_idx;
  logic [ELEN-1:0] wb_data;
  logic            busy;
  logic            done;

  v_regfile_seq #(
    .NREG(NREG), .NELEM(NELEM), .ELEN(ELEN), .RW(RW), .EIW(EIW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .vs1(vs1), .vs2(vs2), .vl(vl), .vm(vm),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx),
    .vs1_data(vs1_data), .vs2_data(vs2_data), .rd_mask(rd_mask),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_idx(wb_idx), .wb_data(wb_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mdl [NREG][NELEM];
  int          clear_left;
  bit          m_run, m_vm, m_done, m_acc;
  int          m_vl, m_rdn, m_wbn, m_vs1, m_vs2;
  logic [31:0] e1, e2;
  logic        em;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic snap(input int k);
    e1 = mdl[m_vs1][k];
    e2 = mdl[m_vs2][k];
    em = m_vm ? 1'b1 : mdl[0][k][0];
  endtask

  task automatic clr_inputs();
    start = 0; vs1 = '0; vs2 = '0; vl = '0; vm = 1'b1; rd_ready = 0;
    wb_valid = 0; wb_reg = '0; wb_idx = '0; wb_data = '0;
  endtask

  // Check outputs against the model, then advance the model across the next edge.
  task automatic step();
    bit exp_valid, exp_busy, hs, acc, wr;
    int wi, wr_r, vlc;
    exp_busy  = (clear_left > 0) || m_run;
    exp_valid = m_run && (m_rdn < m_vl);
    chk("busy", busy, exp_busy);
    chk("start_ready", start_ready, !exp_busy);
    chk("done", done, m_done);
    chk("rd_valid", rd_valid, exp_valid);
    if (exp_valid && rd_valid) begin
      chk("rd_idx", rd_idx, m_rdn);
      chk("vs1_data", vs1_data, e1);
      chk("vs2_data", vs2_data, e2);
      chk("rd_mask", rd_mask, em);
    end
    hs   = exp_valid && rd_ready;
    acc  = !exp_busy && start;
    wi   = int'(wb_idx);
    wr_r = int'(wb_reg);
    wr   = 0;
    if (clear_left == 0 && wb_valid && wi < NELEM && wr_r < NREG)
      wr = !m_run || m_vm || mdl[0][wi][0];
    if (m_run && wb_valid) m_wbn++;
    if (clear_left > 0) begin
      for (int e = 0; e < NELEM; e++) mdl[NREG - clear_left][e] = '0;
      clear_left--;
    end
    if (wr) mdl[wr_r][wi] = wb_data;
    m_done = 0;
    m_acc  = acc;
    if (acc) begin
      vlc = (int'(vl) > NELEM) ? NELEM : int'(vl);
      if (vlc == 0) m_done = 1;
      else begin
        m_run = 1; m_vl = vlc; m_rdn = 0; m_wbn = 0;
        m_vm = vm; m_vs1 = int'(vs1); m_vs2 = int'(vs2);
        snap(0);
      end
    end else if (m_run) begin
      if (hs) begin
        m_rdn++;
        if (m_rdn < m_vl) snap(m_rdn);
      end
      if (m_rdn >= m_vl && m_wbn >= m_vl) begin
        m_run = 0; m_done = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    rst = 1;
    #1;
    chk("rst_start_ready", start_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_vs1_data", vs1_data, 0);
    chk("rst_vs2_data", vs2_data, 0);
    chk("rst_rd_mask", rd_mask, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    m_run = 0; m_done = 0; clear_left = NREG;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic wr_idle(input int r, input int e, input logic [31:0] d);
    wb_valid = 1; wb_reg = RW'(r); wb_idx = EIW'(e); wb_data = d;
    step();
    wb_valid = 0;
  endtask

  // rdmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // wbmode: 0 seq idx random data, 1 every cycle 0xDEAD, 2 out-of-range idx, 3 random, 4 bypass probe.
  task automatic run_instr(input int r1, input int r2, input int vlen, input int vmv,
                           input int rdmode, input int wbmode, input int wbreg,
                           input int abort_at, output int acc_c);
    int c, seq;
    bit started, fin;
    logic [31:0] bypd;
    c = 0; seq = 0; started = 0; fin = 0; acc_c = -1;
    bypd = $urandom;
    while (!fin && c < 400) begin
      start = !started; vs1 = RW'(r1); vs2 = RW'(r2); vl = (EIW+1)'(vlen); vm = vmv[0];
      case (rdmode)
        0: rd_ready = 1;
        1: rd_ready = (c % 4 == 0) || (c % 4 == 3);
        default: rd_ready = $urandom_range(0, 1) != 0;
      endcase
      wb_valid = 0;
      if (m_run) begin
        if (wbmode == 4) begin
          if (c - acc_c == 2) begin
            wb_valid = 1; wb_reg = RW'(r1); wb_idx = EIW'(2); wb_data = bypd;
          end else if (c - acc_c > 2) begin
            wb_valid = 1; wb_reg = RW'(wbreg); wb_idx = EIW'(seq % NELEM); wb_data = $urandom; seq++;
          end
        end else if (wbmode == 1 || $urandom_range(0, 2) != 0) begin
          wb_valid = 1;
          wb_reg   = (wbmode == 3) ? RW'($urandom_range(0, NREG - 1)) : RW'(wbreg);
          wb_idx   = (wbmode == 2) ? EIW'(15) :
                     (wbmode == 3) ? EIW'($urandom_range(0, 11)) : EIW'(seq % NELEM);
          wb_data  = (wbmode == 1) ? 32'hDEAD : $urandom;
          seq++;
        end
      end
      if (abort_at >= 0 && m_run && m_rdn == abort_at) begin
        rst_pulse();
        fin = 1;
      end else begin
        step();
        if (m_acc) begin
          started = 1; acc_c = c;
        end
        if (wbmode == 4 && started && c - acc_c == 2) chk("bypass_vs1", vs1_data, bypd);
        if (started && !m_run) fin = 1;
      end
      c++;
    end
    chk("instr_complete", fin, 1);
    start = 0; wb_valid = 0; rd_ready = 0;
    if (abort_at < 0) step();
  endtask

  initial begin
    int acc;
    bit [0:0] same;
    int r1, r2;
    rst = 1;
    clr_inputs();
    m_run = 0; m_done = 0; clear_left = NREG;
    @(posedge clk); #1;
    rst_pulse();
    repeat (NREG + 1) step();

    // Reset sweep: scribble everywhere, reset, every register must read back zero
    for (int r = 0; r < NREG; r++)
      for (int e = 0; e < NELEM; e++) wr_idle(r, e, $urandom);
    rst_pulse();
    for (int r = 0; r < NREG; r++) begin
      run_instr(r, (r + 5) % NREG, NELEM, 1, 0, 2, 0, -1, acc);
      if (r == 0) chk("clear_latency", acc, NREG);
    end

    // Streaming and backpressure
    for (int i = 0; i < NELEM; i++) begin
      wr_idle(1, i, i);
      wr_idle(2, i, 100 + i);
    end
    run_instr(1, 2, 10, 1, 0, 0, 5, -1, acc);
    run_instr(1, 2, 10, 1, 1, 0, 5, -1, acc);

    // Masking by v0
    for (int i = 0; i < NELEM; i++) begin
      wr_idle(0, i, i & 1);
      wr_idle(3, i, $urandom);
    end
    run_instr(3, 0, 10, 0, 0, 1, 3, -1, acc);
    run_instr(3, 3, 10, 1, 0, 2, 0, -1, acc);

    // Edge lengths, vs1 == vs2
    run_instr(1, 2, 0, 1, 0, 0, 5, -1, acc);
    run_instr(1, 2, 15, 1, 0, 0, 5, -1, acc);
    run_instr(2, 2, 7, 0, 2, 0, 6, -1, acc);

    // Bypass then abort mid-stream
    run_instr(1, 2, 10, 1, 0, 4, 7, -1, acc);
    run_instr(1, 2, 10, 1, 0, 0, 5, 4, acc);
    run_instr(1, 2, 10, 1, 0, 0, 5, -1, acc);
    chk("restart_latency", acc, NREG);

    // Random instructions
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 3; k++)
        wr_idle($urandom_range(0, NREG - 1), $urandom_range(0, NELEM - 1), $urandom);
      r1   = $urandom_range(0, NREG - 1);
      same = 1'($urandom_range(0, 3) == 0);
      r2   = same ? r1 : $urandom_range(0, NREG - 1);
      run_instr(r1, r2, $urandom_range(0, 15), $urandom_range(0, 1), 2, 3, 0, -1, acc);
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/v_regfile_seq.md
# v_regfile_seq

Parametrised vector register file with a built-in element sequencer. For one vector instruction it streams operand pairs (vs1[i], vs2[i]) and the v0 mask bit for elements 0..vl-1 over a valid/ready handshake, and accepts element writebacks with mask gating. It also sweeps the whole array to zero after reset. It sits between the vector decode/issue stage and the vector ALU lanes in the RV32V datapath.

## Interface
- NREG, 32, number of vector registers
- NELEM, 10, elements per register
- ELEN, 32, element width in bits
- RW, 5, register-address width (2^RW >= NREG)
- EIW, 5, element-index width (2^EIW > NELEM)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to begin an instruction
- start_ready  out  1  high only in IDLE; start is accepted when start && start_ready
- vs1, vs2  in  RW  source registers, latched at accept
- vl  in  EIW+1  vector length, latched at accept and clamped to NELEM
- vm  in  1  1 = unmasked; 0 = masked by v0, latched at accept
- rd_valid  out  1  operand element presented
- rd_ready  in  1  consumer accepts the element
- rd_idx  out  EIW  index of the presented element
- vs1_data, vs2_data  out  ELEN  operand values
- rd_mask  out  1  bit 0 of v0[rd_idx], or 1 when vm=1
- wb_valid  in  1  writeback strobe
- wb_reg  in  RW  destination register
- wb_idx  in  EIW  destination element
- wb_data  in  ELEN  write data
- busy  out  1  high in CLEAR and RUN
- done  out  1  one-cycle completion pulse

## Operation
- States: CLEAR, IDLE, RUN.
- CLEAR: entered on rst. Zeros register r (all NELEM elements) in cycle r, for r = 0..NREG-1. Moves to IDLE after register NREG-1. start_ready=0. wb_valid is ignored.
- IDLE: writes are unmasked. On start accept, latch vs1, vs2, vm and vl'=min(vl, NELEM), then go to RUN. If vl'=0, go straight to IDLE with a done pulse.
- RUN, read side:
  - Read counter i runs 0..vl'-1.
  - Output registers hold element i. They advance only on an rd_valid && rd_ready handshake.
  - While rd_ready=0, all rd_* outputs stay stable.
- RUN, write side:
  - Every wb_valid increments wb_cnt.
  - The write is performed only if vm=1 or bit 0 of v0[wb_idx] is 1. Masked-off writebacks still count.
  - wb_idx >= NELEM or wb_reg >= NREG: counted, not written.
- Completion: RUN ends once vl' read handshakes and vl' writebacks have both occurred. done pulses and the state returns to IDLE.
- wb_valid arriving in IDLE after completion performs a plain write; it is not counted.
- Bypass: when a performed write targets the same (reg, idx) that the output registers load in that cycle, wb_data is loaded instead of the old value. This applies to vs1, vs2 and v0/rd_mask.
- vs1 == vs2 is legal; both outputs carry the same data.

## Timing
- Reset values: start_ready=0, rd_valid=0, rd_idx=0, vs1_data=0, vs2_data=0, rd_mask=0, busy=1, done=0, all counters 0.
- CLEAR lasts NREG cycles. start_ready rises at cycle NREG after reset release.
- Start accepted at edge T:
  - rd_valid=1 with element 0 from T+1.
  - With rd_ready held high, element k is presented at T+1+k.
  - Throughput is one element per cycle.
- Read latency after a handshake: 1 cycle to the next element.
- rd_valid drops in the cycle after the last read handshake.
- done=1 for exactly the one cycle after the later of the last read handshake and the last counted writeback. In that same cycle, state=IDLE, busy=0 and start_ready=1.
- vl'=0: start at T gives done=1 at T+1; rd_valid is never asserted.
- rst asserted mid-RUN: the instruction is abandoned immediately. Outputs take reset values and CLEAR restarts from register 0.
- A write performed at edge E is visible to a read loaded at E via bypass, and to any later read.

## Test plan
- Reset sweep: preload via IDLE writes, then pulse rst. After NREG cycles, start_ready=1 and a vl=NELEM read of every register returns 0.
- Streaming: v1[i]=i and v2[i]=100+i, start vl=10 vm=1, rd_ready=1. Elements 0..9 appear on consecutive cycles with (i, 100+i) and rd_mask=1. Return 10 writebacks; done pulses once.
- Backpressure: same setup with rd_ready toggling 1,0,0,1. Outputs are held stable while rd_ready=0, there are no skipped or duplicated indices, and done comes after 10 handshakes.
- Masking: v0[i]=i&1, vm=0, writebacks of 0xDEAD to v3[0..9]. Only the odd elements change, the even elements keep their prior values, and done still pulses after 10 writebacks.
- Edge lengths: vl=0 gives done at T+1 with no rd_valid. vl=15 is clamped to 10 elements.
- Bypass and abort:
  - A writeback to v1[2] at the edge that loads element 2 makes vs1_data show the new value.
  - rst asserted at element 4 gives rd_valid=0 and busy=1, and the next start is accepted only after NREG cycles.
